// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One operation in flight; divide-by-zero and signed overflow bypass the iteration loop.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module div_iter #(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int TAG_WIDTH  = 6,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_en,
    input  logic [2:0]            div_opcode,
    input  logic [WORD_WIDTH-1:0] div_data1,
    input  logic [WORD_WIDTH-1:0] div_data2,
    input  logic [TAG_WIDTH-1:0]  div_tag_in,
    input  logic                  div_flush,
    output logic                  div_busy,
    output logic [WORD_WIDTH-1:0] div_result,
    output logic [TAG_WIDTH-1:0]  div_tag_out,
    output logic                  div_result_valid
);

    // Handshake: an op is taken on an edge where div_busy=0, div_en=1, div_opcode[2]=1 and
    // div_flush=0; the result is qualified by a one-cycle div_result_valid pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WORD_WIDTH-1:0] MIN_NEG  = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(WORD_WIDTH - 1);

    state_t state, state_next;

    logic [WORD_WIDTH-1:0] rem_q;
    logic [WORD_WIDTH-1:0] quo_q;
    logic [WORD_WIDTH-1:0] dvsr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  neg_q_q;
    logic                  neg_r_q;
    logic                  sel_rem_q;

    logic                  accept;
    logic                  is_signed;
    logic                  div_zero;
    logic                  sgn_ovf;
    logic [WORD_WIDTH-1:0] mag_a;
    logic [WORD_WIDTH-1:0] mag_b;
    logic [WORD_WIDTH:0]   shifted;
    logic [WORD_WIDTH:0]   diff;
    logic [WORD_WIDTH-1:0] quo_fix;
    logic [WORD_WIDTH-1:0] rem_fix;

    assign accept    = (state == IDLE) && div_en && div_opcode[2] && !div_flush;
    assign is_signed = ~div_opcode[0];
    assign div_zero  = (div_data2 == '0);
    assign sgn_ovf   = is_signed && (div_data1 == MIN_NEG) && (div_data2 == '1);
    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a     = (is_signed && div_data1[WORD_WIDTH-1]) ? -div_data1 : div_data1;
    assign mag_b     = (is_signed && div_data2[WORD_WIDTH-1]) ? -div_data2 : div_data2;

    assign shifted   = {rem_q, quo_q[WORD_WIDTH-1]};
    assign diff      = shifted - {1'b0, dvsr_q};
    assign quo_fix   = neg_q_q ? -quo_q : quo_q;
    assign rem_fix   = neg_r_q ? -rem_q : rem_q;
    assign div_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (div_zero || sgn_ovf) ? DONE : CALC;
            CALC: if (cnt_q == LAST_CNT) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (div_flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q            <= '0;
            quo_q            <= '0;
            dvsr_q           <= '0;
            cnt_q            <= '0;
            tag_q            <= '0;
            neg_q_q          <= 1'b0;
            neg_r_q          <= 1'b0;
            sel_rem_q        <= 1'b0;
            div_result       <= '0;
            div_tag_out      <= '0;
            div_result_valid <= 1'b0;
        end else begin
            div_result_valid <= 1'b0;
            if (accept) begin
                dvsr_q    <= mag_b;
                tag_q     <= div_tag_in;
                sel_rem_q <= div_opcode[1];
                cnt_q     <= '0;
                neg_r_q   <= is_signed && div_data1[WORD_WIDTH-1];
                // A zero divisor yields an all-ones quotient regardless of operand signs.
                neg_q_q   <= is_signed && (div_data1[WORD_WIDTH-1] ^ div_data2[WORD_WIDTH-1])
                             && !div_zero;
                if (div_zero) begin
                    quo_q <= '1;
                    rem_q <= mag_a;
                end else if (sgn_ovf) begin
                    quo_q <= MIN_NEG;
                    rem_q <= '0;
                end else begin
                    quo_q <= mag_a;
                    rem_q <= '0;
                end
            end else if (state == CALC) begin
                cnt_q <= cnt_q + 1'b1;
                // A failed trial leaves shifted below the divisor, so its top bit is zero.
                if (!diff[WORD_WIDTH]) begin
                    rem_q <= diff[WORD_WIDTH-1:0];
                    quo_q <= {quo_q[WORD_WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[WORD_WIDTH-1:0];
                    quo_q <= {quo_q[WORD_WIDTH-2:0], 1'b0};
                end
            end else if (state == DONE && !div_flush) begin
                div_result       <= sel_rem_q ? rem_fix : quo_fix;
                div_tag_out      <= tag_q;
                div_result_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table, random ops against a reference model,
// and directed flush / reset / back-to-back sequences.
module tb_div_iter;
    localparam int W  = 32;
    localparam int TW = 6;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REM  = 3'b110;
    localparam logic [2:0] OP_REMU = 3'b111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          div_en = 1'b0;
    logic [2:0]    div_opcode = '0;
    logic [W-1:0]  div_data1 = '0;
    logic [W-1:0]  div_data2 = '0;
    logic [TW-1:0] div_tag_in = '0;
    logic          div_flush = 1'b0;
    logic          div_busy;
    logic [W-1:0]  div_result;
    logic [TW-1:0] div_tag_out;
    logic          div_result_valid;

    div_iter #(.WORD_WIDTH(W), .TAG_WIDTH(TW), .CNT_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n), .div_en(div_en), .div_opcode(div_opcode),
        .div_data1(div_data1), .div_data2(div_data2), .div_tag_in(div_tag_in),
        .div_flush(div_flush), .div_busy(div_busy), .div_result(div_result),
        .div_tag_out(div_tag_out), .div_result_valid(div_result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_push = 0;
    logic prev_valid = 1'b0;
    logic [TW+W-1:0] exp_q[$];
    int acc_q[$];
    int lat_q[$];

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        logic [W-1:0] q;
        logic [W-1:0] r;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    // Scoreboard: every valid pulse pops one expectation and checks value, tag and latency.
    always @(negedge clk) begin
        if (div_result_valid) begin
            logic [TW+W-1:0] e;
            int a;
            int l;
            n_valid++;
            check("valid_one_cycle", W'(prev_valid), '0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_valid: got result %h tag %0d, expected no pulse",
                         div_result, div_tag_out);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                l = lat_q.pop_front();
                check("result", div_result, e[W-1:0]);
                check("tag", W'(div_tag_out), W'(e[TW+W-1:W]));
                check("latency", W'(cyc - a), W'(l));
            end
        end
        prev_valid = div_result_valid;
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic [W-1:0] exp, input bit track);
        int guard;
        bit special;
        guard = 0;
        @(negedge clk);
        while (div_busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL busy_timeout: busy still 1 after 200 cycles, expected 0");
        end
        div_en = 1'b1;
        div_opcode = op;
        div_data1 = a;
        div_data2 = b;
        div_tag_in = tag;
        @(posedge clk);
        #1;
        if (track) begin
            special = (b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
            exp_q.push_back({tag, exp});
            acc_q.push_back(cyc);
            lat_q.push_back(special ? 1 : 33);
            n_push++;
        end
        @(negedge clk);
        div_en = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() > 0 || div_busy) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
            lat_q.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0]  = '{OP_DIVU, 32'd100, 32'd7, 6'd5, 32'd14};
        vecs[1]  = '{OP_REMU, 32'd100, 32'd7, 6'd5, 32'd2};
        vecs[2]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 6'd1, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 6'd2, 32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV, 32'd7, 32'hFFFF_FFFE, 6'd3, 32'hFFFF_FFFD};
        vecs[5]  = '{OP_REM, 32'd7, 32'hFFFF_FFFE, 6'd4, 32'd1};
        vecs[6]  = '{OP_DIVU, 32'd5, 32'd0, 6'd6, 32'hFFFF_FFFF};
        vecs[7]  = '{OP_REMU, 32'd5, 32'd0, 6'd7, 32'd5};
        vecs[8]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 32'h8000_0000};
        vecs[9]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9, 32'd0};
        vecs[10] = '{OP_DIV, 32'hFFFF_FFFB, 32'd0, 6'd10, 32'hFFFF_FFFF};
        vecs[11] = '{OP_REM, 32'hFFFF_FFFB, 32'd0, 6'd11, 32'hFFFF_FFFB};
        vecs[12] = '{OP_DIV, 32'h8000_0000, 32'd1, 6'd12, 32'h8000_0000};
        vecs[13] = '{OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 32'd1};

        // Reset state
        #1;
        check("reset_busy", W'(div_busy), '0);
        check("reset_valid", W'(div_result_valid), '0);
        check("reset_result", div_result, '0);
        check("reset_tag", W'(div_tag_out), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp, 1'b1);
            drain();
        end

        for (int i = 0; i < 8; i++) begin
            op = {1'b1, 2'($urandom_range(0, 3))};
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
            issue(op, a, b, TW'($urandom_range(0, 63)), model(op, a, b), 1'b1);
            drain();
        end

        // Flush during CALC: no pulse, busy drops after the flush edge
        issue(OP_DIVU, 32'd100, 32'd7, 6'd9, '0, 1'b0);
        repeat (9) @(negedge clk);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        check("flush_calc_busy", W'(div_busy), '0);
        repeat (40) @(negedge clk);
        check("flush_calc_idle", W'(div_busy), '0);

        // Next op completes normally; an issue attempt while busy is ignored
        issue(OP_DIVU, 32'd9, 32'd3, 6'd11, 32'd3, 1'b1);
        repeat (5) @(negedge clk);
        div_en = 1'b1;
        div_opcode = OP_DIVU;
        div_data1 = 32'd50;
        div_data2 = 32'd5;
        div_tag_in = 6'd12;
        @(negedge clk);
        div_en = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        // Flush landing on the DONE cycle of a fast-path op
        issue(OP_DIVU, 32'd5, 32'd0, 6'd13, '0, 1'b0);
        div_flush = 1'b1;
        @(negedge clk);
        div_flush = 1'b0;
        check("flush_done_busy", W'(div_busy), '0);
        repeat (4) @(negedge clk);

        // Flush together with issue: not accepted
        div_en = 1'b1;
        div_flush = 1'b1;
        div_opcode = OP_DIVU;
        div_data1 = 32'd8;
        div_data2 = 32'd2;
        div_tag_in = 6'd14;
        @(negedge clk);
        div_en = 1'b0;
        div_flush = 1'b0;
        check("flush_en_no_accept", W'(div_busy), '0);
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-CALC
        issue(OP_DIVU, 32'd1000, 32'd3, 6'd20, '0, 1'b0);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", W'(div_busy), '0);
        check("async_rst_valid", W'(div_result_valid), '0);
        check("async_rst_result", div_result, '0);
        check("async_rst_tag", W'(div_tag_out), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 6'd21, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Back-to-back: second op accepted on the edge ending the first valid cycle
        issue(OP_DIV, 32'd20, 32'hFFFF_FFFC, 6'd22, 32'hFFFF_FFFB, 1'b1);
        issue(OP_REMU, 32'd20, 32'd6, 6'd23, 32'd2, 1'b1);
        drain();
        repeat (5) @(negedge clk);

        check("valid_pulse_count", W'(n_valid), W'(n_push));
        check("scoreboard_empty", W'(exp_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
